exe_unit_seq: RTL and testbench

//  Sequential, handshaked successor of the combinational execution unit. Accepts one

---
 rtl/exe_unit_pkg.sv | 39 +++
 rtl/crc_serial_core.sv | 71 +++++++
 rtl/exe_unit_seq.sv | 191 +++++++++++++++++++
 tb/tb_exe_unit_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/exe_unit_pkg.sv
// Shared types and helpers for the sequential execution unit.
package exe_unit_pkg;

  // Opcode map; values above OP_CRC4 are illegal and execute as OP_SUB.
  typedef enum logic [3:0] {
    OP_SUB       = 4'd0,
    OP_OR        = 4'd1,
    OP_NOR       = 4'd2,
    OP_SRA_A     = 4'd3,
    OP_SRA_B     = 4'd4,
    OP_SRL_A     = 4'd5,
    OP_SRL_B     = 4'd6,
    OP_POPC      = 4'd7,
    OP_U2U1      = 4'd8,
    OP_GRAY      = 4'd9,
    OP_THERM_ENC = 4'd10,
    OP_THERM_DEC = 4'd11,
    OP_CRC3      = 4'd12,
    OP_CRC4      = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int OP_LAST  = 13;
  localparam int CRC_KMAX = 4;

  // Number of set bits in a word of up to 32 bits.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/crc_serial_core.sv
// Bit-serial CRC engine: loads a data word and polynomial, then consumes one
// data bit per clock (MSB first) for WIDTH clocks. K is KMAX or KMAX-1.
module crc_serial_core #(
  parameter int WIDTH = 4,
  parameter int KMAX  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic [KMAX-1:0] i_poly,
  input  logic            i_kmax,
  output logic            o_last,
  output logic [KMAX-1:0] o_crc_next
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [KMAX-1:0]  crc_q, crc_d;
  logic [KMAX-1:0]  poly_q, poly_d;
  logic             kmax_q, kmax_d;
  logic [KMAX-1:0]  mask;
  logic             top_bit;
  logic             fb;

  // One LFSR step on the current head bit; the mask drops x^K for K=KMAX-1.
  always_comb begin
    mask       = kmax_q ? {KMAX{1'b1}} : {1'b0, {(KMAX-1){1'b1}}};
    top_bit    = kmax_q ? crc_q[KMAX-1] : crc_q[KMAX-2];
    fb         = shreg_q[WIDTH-1] ^ top_bit;
    o_crc_next = ({crc_q[KMAX-2:0], 1'b0} ^ (fb ? poly_q : {KMAX{1'b0}})) & mask;
    o_last     = (cnt_q == CW'(1));
  end

  // Load a new job, or advance one bit while bits remain.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    crc_d   = crc_q;
    poly_d  = poly_q;
    kmax_d  = kmax_q;
    if (i_load) begin
      cnt_d   = CW'(WIDTH);
      shreg_d = i_data;
      crc_d   = '0;
      poly_d  = i_poly;
      kmax_d  = i_kmax;
    end else if (cnt_q != '0) begin
      cnt_d   = cnt_q - CW'(1);
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      crc_d   = o_crc_next;
    end
  end

  // Bit counter is the only control state; reset aborts a running job.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Data registers are only meaningful while the counter runs.
  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
    crc_q   <= crc_d;
    poly_q  <= poly_d;
    kmax_q  <= kmax_d;
  end

endmodule

// File: rtl/exe_unit_seq.sv
// Handshaked execution unit: single-cycle ALU ops complete on the accept edge,
// CRC-3/CRC-4 run bit-serially for WIDTH clocks. One registered output stage.
module exe_unit_seq
  import exe_unit_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OPW   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_argA,
  input  logic [WIDTH-1:0] i_argB,
  input  logic [OPW-1:0]   i_oper,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ZF,
  output logic             o_SF,
  output logic             o_PF,
  output logic             o_OF,
  output logic             o_ILL
);

  state_e state_q, state_d;

  logic                    accept;
  logic                    is_ill;
  logic                    is_crc;
  op_e                     op_eff;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        alu_r;
  logic                    alu_of;
  logic                    therm_run;

  logic                    crc_last;
  logic [CRC_KMAX-1:0]     crc_next;

  logic                    load;
  logic [WIDTH-1:0]        new_r;
  logic                    new_of, new_ill;

  logic [WIDTH-1:0]        result_q, result_d;
  logic                    zf_q, zf_d, sf_q, sf_d, pf_q, pf_d;
  logic                    of_q, of_d, ill_q, ill_d;

  assign accept = i_valid & o_ready;
  assign a_s    = $signed(i_argA);
  assign b_s    = $signed(i_argB);

  // Opcode decode; illegal opcodes fall back to subtraction.
  always_comb begin
    is_ill = (i_oper > OPW'(OP_LAST));
    op_eff = is_ill ? OP_SUB : op_e'(i_oper[3:0]);
    is_crc = (op_eff == OP_CRC3) | (op_eff == OP_CRC4);
  end

  // Single-cycle datapath, evaluated directly on the presented operands.
  always_comb begin
    alu_r     = '0;
    alu_of    = 1'b0;
    therm_run = 1'b1;
    case (op_eff)
      OP_SUB: begin
        alu_r  = i_argA - i_argB;
        alu_of = (i_argA[WIDTH-1] ^ i_argB[WIDTH-1]) & (alu_r[WIDTH-1] ^ i_argA[WIDTH-1]);
      end
      OP_OR:    alu_r = i_argA | i_argB;
      OP_NOR:   alu_r = ~(i_argA | i_argB);
      OP_SRA_A: alu_r = a_s >>> 1;
      OP_SRA_B: alu_r = b_s >>> 1;
      OP_SRL_A: alu_r = i_argA >> 1;
      OP_SRL_B: alu_r = i_argB >> 1;
      OP_POPC:  alu_r = WIDTH'(popcount(32'(i_argA))) + WIDTH'(popcount(32'(i_argB)));
      OP_U2U1:  alu_r = i_argA[WIDTH-1] ? (i_argA - WIDTH'(1)) : i_argA;
      OP_GRAY: begin
        // Binary bit i is the parity of Gray bits i..MSB.
        for (int i = 0; i < WIDTH; i++) alu_r[i] = ^(i_argA >> i);
      end
      OP_THERM_ENC: begin
        for (int i = 0; i < WIDTH; i++) alu_r[i] = (32'(i_argA) > 32'(i));
      end
      OP_THERM_DEC: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (therm_run & i_argA[i]) alu_r = alu_r + WIDTH'(1);
          else                       therm_run = 1'b0;
        end
      end
      default: alu_r = '0;
    endcase
  end

  crc_serial_core #(
    .WIDTH (WIDTH),
    .KMAX  (CRC_KMAX)
  ) u_crc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (accept & is_crc),
    .i_data     (i_argA),
    .i_poly     (i_argB[CRC_KMAX-1:0]),
    .i_kmax     (op_eff == OP_CRC4),
    .o_last     (crc_last),
    .o_crc_next (crc_next)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; DONE can chain straight into the next job.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_crc ? CALC : DONE;
      CALC: if (crc_last) state_d = DONE;
      DONE: if (i_ready) state_d = accept ? (is_crc ? CALC : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_valid = (state_q == DONE);
    o_ready = (state_q == IDLE) | ((state_q == DONE) & i_ready);
  end

  // Select what, if anything, lands in the output stage this cycle.
  always_comb begin
    load    = 1'b0;
    new_r   = alu_r;
    new_of  = alu_of;
    new_ill = is_ill;
    if (accept & ~is_crc) begin
      load = 1'b1;
    end else if ((state_q == CALC) & crc_last) begin
      load    = 1'b1;
      new_r   = WIDTH'(crc_next);
      new_of  = 1'b0;
      new_ill = 1'b0;
    end
  end

  // Output stage next values; flags are derived from the result being stored.
  always_comb begin
    result_d = result_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    pf_d     = pf_q;
    of_d     = of_q;
    ill_d    = ill_q;
    if (load) begin
      result_d = new_r;
      zf_d     = (new_r == '0);
      sf_d     = new_r[WIDTH-1];
      pf_d     = ~^new_r;
      of_d     = new_of;
      ill_d    = new_ill;
    end
  end

  // Output stage registers; cleared on reset so an aborted job leaves nothing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_q <= '0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      pf_q     <= 1'b0;
      of_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      pf_q     <= pf_d;
      of_q     <= of_d;
      ill_q    <= ill_d;
    end
  end

  assign o_result = result_q;
  assign o_ZF     = zf_q;
  assign o_SF     = sf_q;
  assign o_PF     = pf_q;
  assign o_OF     = of_q;
  assign o_ILL    = ill_q;

endmodule

// File: tb/tb_exe_unit_seq.sv
// Scoreboard bench for exe_unit_seq at WIDTH=4.
module tb_exe_unit_seq;

  localparam int WIDTH = 4;
  localparam int OPW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_rst, i_valid, i_ready;
  logic [3:0] i_argA, i_argB, i_oper;
  logic       o_ready, o_valid;
  logic [3:0] o_result;
  logic       o_ZF, o_SF, o_PF, o_OF, o_ILL;

  exe_unit_seq #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_argA   (i_argA),
    .i_argB   (i_argB),
    .i_oper   (i_oper),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_ZF     (o_ZF),
    .o_SF     (o_SF),
    .o_PF     (o_PF),
    .o_OF     (o_OF),
    .o_ILL    (o_ILL)
  );

  typedef struct packed {
    logic [3:0] r;
    logic zf, sf, pf, of, ill;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected record from a hand-computed result plus OF/ILL.
  function automatic exp_t mk(input logic [3:0] r, input logic of, input logic ill);
    exp_t e;
    e.r   = r;
    e.zf  = (r == 4'd0);
    e.sf  = r[3];
    e.pf  = ~^r;
    e.of  = of;
    e.ill = ill;
    return e;
  endfunction

  // Present a request just after a rising edge and hold it until accepted.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int n;
    i_valid = 1'b1;
    i_argA  = a;
    i_argB  = b;
    i_oper  = op;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) check("accept_timeout", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Monitor: every completed output transfer is compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!i_rst && o_valid && i_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'({o_result, o_ZF, o_SF, o_PF, o_OF, o_ILL}), 32'h1FF);
        end else begin
          e = sb.pop_front();
          check("result", 32'({o_result, o_ZF, o_SF, o_PF, o_OF, o_ILL}), 32'(e));
        end
      end
    end
  end

  // Directed table: A, B, opcode, expected result, OF, ILL.
  logic [3:0] t_a   [19] = '{4'd10, 4'd8, 4'd0, 4'd9, 4'd0, 4'd12, 4'd6, 4'd3, 4'd9, 4'd7,
                             4'd15, 4'd11, 4'd8, 4'd5, 4'd8, 4'd0, 4'd5, 4'd0, 4'd2};
  logic [3:0] t_b   [19] = '{4'd4, 4'd0, 4'd6, 4'd0, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                             4'd0, 4'd0, 4'd3, 4'd5, 4'd1, 4'd0, 4'd0, 4'd9, 4'd3};
  logic [3:0] t_op  [19] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd10, 4'd11,
                             4'd11, 4'd11, 4'd13, 4'd0, 4'd0, 4'd1, 4'd8, 4'd4, 4'd14};
  logic [3:0] t_r   [19] = '{4'd1, 4'd12, 4'd3, 4'd4, 4'd7, 4'd11, 4'd4, 4'd7, 4'd15, 4'd3,
                             4'd4, 4'd2, 4'd11, 4'd0, 4'd7, 4'd0, 4'd5, 4'd12, 4'd15};
  logic       t_of  [19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  logic       t_ill [19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  // Stimulus.
  initial begin
    int n;
    int ready_seen;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_argA  = '0;
    i_argB  = '0;
    i_oper  = '0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_result", 32'(o_result), 32'd0);
    check("rst_flags", 32'({o_ZF, o_SF, o_PF, o_OF, o_ILL}), 32'd0);
    @(posedge clk);
    #1;

    // 3 - 5 = -2
    sb.push_back(mk(4'hE, 1'b0, 1'b0));
    send(4'd3, 4'd5, 4'd0);
    @(negedge clk);
    check("op0_valid", 32'(o_valid), 32'd1);
    check("op0_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;

    // CRC-3 of 1101 with g = x^3+x+1
    sb.push_back(mk(4'b0001, 1'b0, 1'b0));
    send(4'b1101, 4'b0011, 4'd12);
    n = 0;
    ready_seen = 0;
    @(negedge clk);
    while (!o_valid && n < 20) begin
      if (o_ready) ready_seen++;
      n++;
      @(negedge clk);
    end
    check("crc_calc_cycles", 32'(n), 32'd4);
    check("crc_ready_low", 32'(ready_seen), 32'd0);
    @(posedge clk);
    #1;

    // Overflowing subtract, then the same as an illegal opcode, back to back
    sb.push_back(mk(4'd8, 1'b1, 1'b0));
    send(4'd7, 4'hF, 4'd0);
    sb.push_back(mk(4'd8, 1'b1, 1'b1));
    send(4'd7, 4'hF, 4'd15);

    // Consumer stall: result must hold, new request must be refused
    repeat (2) @(posedge clk);
    #1;
    i_ready = 1'b0;
    sb.push_back(mk(4'd7, 1'b0, 1'b0));
    send(4'd5, 4'd2, 4'd1);
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_argA  = 4'd1;
      i_argB  = 4'd1;
      i_oper  = 4'd0;
      @(negedge clk);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_result", 32'(o_result), 32'd7);
      check("hold_ready", 32'(o_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ignored_req", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a CRC job
    send(4'hF, 4'd3, 4'd13);
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_result", 32'(o_result), 32'd0);
    @(posedge clk);
    #1;
    sb.push_back(mk(4'd5, 1'b0, 1'b0));
    send(4'hF, 4'd1, 4'd7);

    // Remaining opcodes, issued back to back
    for (int i = 0; i < 19; i++) begin
      sb.push_back(mk(t_r[i], t_of[i], t_ill[i]));
      send(t_a[i], t_b[i], t_op[i]);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
